// File: rtl/fp_norm_pkg.sv
// Shared constants and types for the floating-point normalise/round datapath.
package fp_norm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

    localparam int DEF_WIDTH   = 26;
    localparam int DEF_EXP_W   = 8;
    localparam int DEF_EXP_MIN = 1;

    // Width needed to hold a shift count of 0..w.
    function automatic int shamt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fp_norm_shifter_lzc_window.sv
// Leading-zero count over the top STEP bits of the mantissa; STEP when all zero.
module lzc_window #(
    parameter int STEP = 4
) (
    input  logic [STEP-1:0]              window,
    output logic [$clog2(STEP+1)-1:0]    lz
);

    localparam int LZW = $clog2(STEP + 1);

    logic found;

    always_comb begin
        lz    = LZW'(STEP);
        found = 1'b0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (!found && window[STEP-1-i]) begin
                lz    = LZW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_norm_shifter.sv
// Multi-cycle mantissa normaliser: shifts left up to STEP bits per clock,
// tracking the exponent and clamping it at EXP_MIN to produce denormals.
module fp_norm_shifter
    import fp_norm_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int EXP_W   = DEF_EXP_W,
    parameter int STEP    = 4,
    parameter int EXP_MIN = DEF_EXP_MIN
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_mant,
    input  logic [EXP_W-1:0]              in_exp,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_mant,
    output logic [EXP_W-1:0]              out_exp,
    output logic [shamt_width(WIDTH)-1:0] out_shamt,
    output logic                          out_zero,
    output logic                          out_denorm,
    output logic                          busy
);

    localparam int SHW = shamt_width(WIDTH);
    localparam int LZW = $clog2(STEP + 1);
    localparam int CW  = (EXP_W > LZW) ? EXP_W : LZW;

    norm_state_t      state;
    logic [WIDTH-1:0] mant;
    logic [EXP_W-1:0] exp_r;
    logic [SHW-1:0]   shamt;
    logic             zero;
    logic             denorm;

    logic [LZW-1:0]   lz;
    logic [EXP_W-1:0] room;
    logic [CW-1:0]    room_c;
    logic [CW-1:0]    lz_c;
    logic [LZW-1:0]   s;

    lzc_window #(.STEP(STEP)) u_lzc (
        .window (mant[WIDTH-1 -: STEP]),
        .lz     (lz)
    );

    // Shift is limited by the remaining exponent headroom above EXP_MIN.
    always_comb begin
        room   = (exp_r > EXP_W'(EXP_MIN)) ? exp_r - EXP_W'(EXP_MIN) : '0;
        room_c = CW'(room);
        lz_c   = CW'(lz);
        s      = LZW'((room_c < lz_c) ? room_c : lz_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mant   <= '0;
            exp_r  <= '0;
            shamt  <= '0;
            zero   <= 1'b0;
            denorm <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mant   <= in_mant;
                        exp_r  <= in_exp;
                        shamt  <= '0;
                        zero   <= 1'b0;
                        denorm <= 1'b0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (mant == '0) begin
                        zero  <= 1'b1;
                        exp_r <= '0;
                        shamt <= '0;
                        state <= DONE;
                    end else if (mant[WIDTH-1]) begin
                        state <= DONE;
                    end else if (exp_r <= EXP_W'(EXP_MIN)) begin
                        denorm <= 1'b1;
                        state  <= DONE;
                    end else begin
                        mant  <= mant << s;
                        exp_r <= exp_r - EXP_W'(s);
                        shamt <= shamt + SHW'(s);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign out_mant   = mant;
    assign out_exp    = exp_r;
    assign out_shamt  = shamt;
    assign out_zero   = zero;
    assign out_denorm = denorm;

endmodule

// File: tb/tb_fp_norm_shifter.sv
// Directed bench for fp_norm_shifter at default parameters (26/8/STEP=4/EXP_MIN=1).
module tb_fp_norm_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [25:0] in_mant = '0;
    logic [7:0]  in_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [25:0] out_mant;
    logic [7:0]  out_exp;
    logic [4:0]  out_shamt;
    logic        out_zero;
    logic        out_denorm;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    fp_norm_shifter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_exp    (out_exp),
        .out_shamt  (out_shamt),
        .out_zero   (out_zero),
        .out_denorm (out_denorm),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Present an operand, accept it on the next edge, then wait (bounded) for out_valid.
    task automatic run_op(input string tag, input logic [25:0] m, input logic [7:0] e,
                          input int lat_exp, input logic [25:0] m_exp, input logic [7:0] e_exp,
                          input logic [4:0] sh_exp, input logic z_exp, input logic d_exp);
        int lat;
        in_mant  = m;
        in_exp   = e;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_lat"},    lat,        lat_exp);
        check({tag, "_mant"},   out_mant,   m_exp);
        check({tag, "_exp"},    out_exp,    e_exp);
        check({tag, "_shamt"},  out_shamt,  sh_exp);
        check({tag, "_zero"},   out_zero,   z_exp);
        check({tag, "_denorm"}, out_denorm, d_exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit saw_valid;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_busy",      busy,      0);
        check("rst_mant",      out_mant,  0);
        check("rst_exp",       out_exp,   0);
        check("rst_shamt",     out_shamt, 0);
        check("rst_zero",      out_zero,  0);
        check("rst_denorm",    out_denorm, 0);
        rst_n = 1'b1;
        step();

        // Already normalised, long shift, clamped denormal, zero
        run_op("s1", 26'h2000000, 8'd100, 2, 26'h2000000, 8'd100, 5'd0, 1'b0, 1'b0);
        step();
        run_op("s2", 26'h0000001, 8'd100, 9, 26'h2000000, 8'd75, 5'd25, 1'b0, 1'b0);
        step();
        run_op("s3", 26'h0000100, 8'd10, 5, 26'h0020000, 8'd1, 5'd9, 1'b0, 1'b1);
        step();
        run_op("s4", 26'h0000000, 8'd57, 2, 26'h0000000, 8'd0, 5'd0, 1'b1, 1'b0);
        step();
        // Exponent at or below EXP_MIN: no shift, denormal
        run_op("emin", 26'h0000001, 8'd1, 2, 26'h0000001, 8'd1, 5'd0, 1'b0, 1'b1);
        step();
        run_op("ebelow", 26'h0000010, 8'd0, 2, 26'h0000010, 8'd0, 5'd0, 1'b0, 1'b1);
        step();

        // Backpressure: hold DONE for 5 cycles with out_ready low
        out_ready = 1'b0;
        run_op("s5", 26'h2000000, 8'd100, 2, 26'h2000000, 8'd100, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid",    out_valid, 1);
            check("hold_in_ready", in_ready,  0);
            check("hold_mant",     out_mant,  26'h2000000);
            check("hold_exp",      out_exp,   100);
            if (i < 4) step();
            else begin
                // Handshake cycle: a simultaneous input must be ignored.
                in_mant   = 26'h0;
                in_exp    = 8'd57;
                in_valid  = 1'b1;
                out_ready = 1'b1;
                step();
            end
        end
        check("post_hs_in_ready",  in_ready,  1);
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_busy",      busy,      0);
        run_op("b2b", 26'h0000100, 8'd10, 5, 26'h0020000, 8'd1, 5'd9, 1'b0, 1'b1);
        step();

        // Asynchronous reset during the 3rd shift cycle of a long normalisation
        in_mant  = 26'h0000001;
        in_exp   = 8'd100;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        step();
        step();
        check("pre_rst_busy",  busy,      1);
        check("pre_rst_shamt", out_shamt, 8);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy",      busy,      0);
        check("arst_in_ready",  in_ready,  1);
        check("arst_mant",      out_mant,  0);
        check("arst_exp",       out_exp,   0);
        check("arst_shamt",     out_shamt, 0);
        #3 rst_n = 1'b1;
        step();
        check("rel_in_ready", in_ready, 1);
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) saw_valid = 1'b1;
            step();
        end
        check("no_stale_result", saw_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
